// File: rtl/seg_pkg.sv
// Shared definitions for the segment scan controller: FSM encoding and the
// active-low {g,f,e,d,c,b,a} hex pattern table.
package seg_pkg;

    typedef enum logic [1:0] {
        StOff   = 2'd0,
        StBlank = 2'd1,
        StDrive = 2'd2
    } state_e;

    localparam logic [7:0] SEG_OFF = 8'hFF;

    // Entry n is the active-low pattern for hex digit n (entry 15 listed first).
    localparam logic [15:0][6:0] HEX_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/segment_scan_controller_if.sv
// Display-side bundle of the segment scan controller: control/data inputs
// from the host and the multiplexed anode/segment drive back out.
interface segment_scan_controller_if #(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned DATA_W     = 32
);
    localparam int unsigned PAGES  = DATA_W / (4 * NUM_DIGITS);
    localparam int unsigned PAGE_W = (PAGES > 1) ? $clog2(PAGES) : 1;

    logic                  ena;
    logic                  we;
    logic [PAGE_W-1:0]     page_sel;
    logic [DATA_W-1:0]     data_in;
    logic [NUM_DIGITS-1:0] dp_in;
    logic [NUM_DIGITS-1:0] an;
    logic [7:0]            seg;

    modport master (
        output ena, we, page_sel, data_in, dp_in,
        input  an, seg
    );

    modport slave (
        input  ena, we, page_sel, data_in, dp_in,
        output an, seg
    );

endinterface

// File: rtl/seg_hex_decoder.sv
// Combinational nibble to active-low 7-segment pattern lookup.
module seg_hex_decoder
    import seg_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] pat_o
);

    assign pat_o = HEX_TABLE[nib_i];

endmodule

// File: rtl/segment_scan_controller.sv
// Multiplexed 7-segment scan controller with blanking between digits.
// Optional leading-zero suppression is enabled by defining SEG_LZ_BLANK_EN.
module segment_scan_controller
    import seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned DIV_W      = 18,
    parameter int unsigned BLANK_CYC  = 16
) (
    input logic                      clk,
    input logic                      rst,
    segment_scan_controller_if.slave bus
);

    localparam int unsigned PAGES   = DATA_W / (4 * NUM_DIGITS);
    localparam int unsigned IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned BLANK_W = DIV_W + 1;

    localparam logic [DIV_W-1:0]   REFRESH_MAX = '1;
    localparam logic [BLANK_W-1:0] BLANK_LAST  = BLANK_W'(BLANK_CYC - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST    = IDX_W'(NUM_DIGITS - 1);

    state_e                state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DIV_W-1:0]      refresh_q, refresh_d;
    logic [BLANK_W-1:0]    blank_q, blank_d;
    logic [DATA_W-1:0]     hold_q, hold_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [7:0]            seg_q, seg_d;

    logic [3:0]            page_nib [NUM_DIGITS];
    int unsigned           eff_page;
    logic [3:0]            nib;
    logic                  dp_sel;
    logic [NUM_DIGITS-1:0] an_sel;
    logic [6:0]            pat;
`ifdef SEG_LZ_BLANK_EN
    logic                  all_zero;
    logic                  lz_blank;
`endif

    // Dropping ena overrides every state and parks the digit index.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        refresh_d = refresh_q;
        blank_d   = blank_q;
        hold_d    = bus.we ? bus.data_in : hold_q;
        if (!bus.ena) begin
            state_d   = StOff;
            refresh_d = '0;
            blank_d   = '0;
        end else begin
            case (state_q)
                StOff: begin
                    state_d = StBlank;
                    blank_d = '0;
                end
                StBlank: begin
                    if (blank_q == BLANK_LAST) begin
                        state_d   = StDrive;
                        refresh_d = '0;
                    end else begin
                        blank_d = blank_q + BLANK_W'(1);
                    end
                end
                StDrive: begin
                    if (refresh_q == REFRESH_MAX) begin
                        state_d   = StBlank;
                        blank_d   = '0;
                        refresh_d = '0;
                        idx_d     = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
                    end else begin
                        refresh_d = refresh_q + DIV_W'(1);
                    end
                end
                default: state_d = StOff;
            endcase
        end
    end

    // Out-of-range page selects fall back to page 0.
    always_comb begin
        eff_page = (32'(bus.page_sel) >= PAGES) ? 0 : 32'(bus.page_sel);
        for (int unsigned d = 0; d < NUM_DIGITS; d++) begin
            page_nib[d] = '0;
            for (int unsigned pg = 0; pg < PAGES; pg++) begin
                if (eff_page == pg) page_nib[d] = hold_q[(pg*NUM_DIGITS+d)*4 +: 4];
            end
        end
    end

    // Walk from the top digit down so leading-zero state is known at each position.
    always_comb begin
        nib    = '0;
        dp_sel = 1'b0;
        an_sel = '1;
`ifdef SEG_LZ_BLANK_EN
        all_zero = 1'b1;
        lz_blank = 1'b0;
`endif
        for (int d = NUM_DIGITS - 1; d >= 0; d--) begin
`ifdef SEG_LZ_BLANK_EN
            all_zero = all_zero && (page_nib[d] == 4'h0);
`endif
            if (idx_d == IDX_W'(d)) begin
                nib       = page_nib[d];
                dp_sel    = bus.dp_in[d];
                an_sel[d] = 1'b0;
`ifdef SEG_LZ_BLANK_EN
                lz_blank  = all_zero && (d != 0);
`endif
            end
        end
    end

    seg_hex_decoder u_hex (
        .nib_i (nib),
        .pat_o (pat)
    );

    // Outputs are registered from the next state so they line up with state_q.
    always_comb begin
        an_d  = '1;
        seg_d = SEG_OFF;
        if (state_d == StDrive) begin
            an_d  = an_sel;
            seg_d = {~dp_sel, pat};
`ifdef SEG_LZ_BLANK_EN
            if (lz_blank) seg_d[6:0] = SEG_OFF[6:0];
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StOff;
            idx_q     <= '0;
            refresh_q <= '0;
            blank_q   <= '0;
            hold_q    <= '0;
            an_q      <= '1;
            seg_q     <= SEG_OFF;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            refresh_q <= refresh_d;
            blank_q   <= blank_d;
            hold_q    <= hold_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
        end
    end

    assign bus.an  = an_q;
    assign bus.seg = seg_q;

endmodule

// File: tb/tb_segment_scan_controller.sv
// Directed bench for segment_scan_controller (4 digits, DIV_W=2, BLANK_CYC=1).
// Honours SEG_LZ_BLANK_EN when choosing leading-zero expectations.
module tb_segment_scan_controller;

    localparam int unsigned ND = 4;
    localparam int unsigned DW = 32;

    logic clk;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;

    segment_scan_controller_if #(.NUM_DIGITS(ND), .DATA_W(DW)) bus ();

    segment_scan_controller #(
        .NUM_DIGITS (ND),
        .DATA_W     (DW),
        .DIV_W      (2),
        .BLANK_CYC  (1)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected {an, seg} k cycles after ena rises from OFF with index 0:
    // 1 blank cycle then 4 drive cycles per digit. segs holds digit d at [d*8 +: 8].
    function automatic logic [11:0] scan_exp(input int k, input logic [31:0] segs);
        int       pos;
        int       d;
        logic [3:0] one;
        pos = (k - 1) % 5;
        d   = ((k - 1) / 5) % 4;
        one = 4'b0001;
        if (pos == 0) return {4'b1111, 8'hFF};
        return {~(one << d), segs[d*8 +: 8]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        bus.ena      = 1'b0;
        bus.we       = 1'b0;
        bus.page_sel = '0;
        bus.data_in  = '0;
        bus.dp_in    = '0;
        #2 rst = 1'b0;
        #1;
        n_vec++;
        if ({bus.an, bus.seg} !== {4'b1111, 8'hFF}) begin
            n_err++;
            $display("FAIL reset_async an/seg=%b/%h expected 1111/ff", bus.an, bus.seg);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++;
            if ({bus.an, bus.seg} !== {4'b1111, 8'hFF}) begin
                n_err++;
                $display("FAIL reset_hold an/seg=%b/%h expected 1111/ff", bus.an, bus.seg);
            end
        end
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            n_vec++;
            if ({bus.an, bus.seg} !== {4'b1111, 8'hFF}) begin
                n_err++;
                $display("FAIL idle_off cyc=%0d an/seg=%b/%h expected 1111/ff", i, bus.an, bus.seg);
            end
        end
    endtask

    task automatic test_load(input logic [31:0] word);
        bus.we      = 1'b1;
        bus.data_in = word;
        tick();
        bus.we = 1'b0;
        n_vec++;
        if ({bus.an, bus.seg} !== {4'b1111, 8'hFF}) begin
            n_err++;
            $display("FAIL load_off an/seg=%b/%h expected 1111/ff", bus.an, bus.seg);
        end
    endtask

    task automatic test_scan(input string name, input logic page, input logic [3:0] dp,
                             input logic [31:0] segs);
        logic [11:0] e;
        bus.page_sel = page;
        bus.dp_in    = dp;
        bus.ena      = 1'b1;
        for (int k = 1; k <= 25; k++) begin
            tick();
            e = scan_exp(k, segs);
            n_vec++;
            if ({bus.an, bus.seg} !== e) begin
                n_err++;
                $display("FAIL %s k=%0d an/seg=%b/%h expected %b/%h",
                         name, k, bus.an, bus.seg, e[11:8], e[7:0]);
            end
        end
        bus.ena = 1'b0;
        tick();
        n_vec++;
        if ({bus.an, bus.seg} !== {4'b1111, 8'hFF}) begin
            n_err++;
            $display("FAIL %s_off an/seg=%b/%h expected 1111/ff", name, bus.an, bus.seg);
        end
        bus.dp_in = '0;
    endtask

    // Word 89AB_1267 written on the second drive cycle of digit 0; timing must not slip.
    task automatic test_write_during_drive();
        logic [11:0] e;
        bus.page_sel = 1'b0;
        bus.ena      = 1'b1;
        for (int k = 1; k <= 25; k++) begin
            tick();
            if (k >= 5) begin
                e = scan_exp(k, 32'hF9A4_82F8);
                n_vec++;
                if ({bus.an, bus.seg} !== e) begin
                    n_err++;
                    $display("FAIL wr_drive k=%0d an/seg=%b/%h expected %b/%h",
                             k, bus.an, bus.seg, e[11:8], e[7:0]);
                end
            end
            if (k == 2) begin
                bus.we      = 1'b1;
                bus.data_in = 32'h89AB_1267;
            end
            if (k == 3) bus.we = 1'b0;
        end
        bus.ena = 1'b0;
        tick();
    endtask

    task automatic test_ena_drop();
        logic [11:0] e;
        bus.page_sel = 1'b0;
        bus.ena      = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            tick();
            e = scan_exp(k, 32'hF9A4_B099);
            n_vec++;
            if ({bus.an, bus.seg} !== e) begin
                n_err++;
                $display("FAIL drop_pre k=%0d an/seg=%b/%h expected %b/%h",
                         k, bus.an, bus.seg, e[11:8], e[7:0]);
            end
        end
        bus.ena = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++;
            if ({bus.an, bus.seg} !== {4'b1111, 8'hFF}) begin
                n_err++;
                $display("FAIL drop_off i=%0d an/seg=%b/%h expected 1111/ff", i, bus.an, bus.seg);
            end
        end
        bus.ena = 1'b1;
        for (int j = 0; j < 7; j++) begin
            tick();
            if (j == 0 || j == 5)      e = {4'b1111, 8'hFF};
            else if (j == 6)           e = {4'b0111, 8'hF9};
            else                       e = {4'b1011, 8'hA4};
            n_vec++;
            if ({bus.an, bus.seg} !== e) begin
                n_err++;
                $display("FAIL drop_resume j=%0d an/seg=%b/%h expected %b/%h",
                         j, bus.an, bus.seg, e[11:8], e[7:0]);
            end
        end
        bus.ena = 1'b0;
        tick();
    endtask

    // Reset mid-scan must clear outputs at once, and clear index and hold word.
    task automatic test_async_reset();
        bus.ena = 1'b1;
        for (int k = 0; k < 8; k++) tick();
        #2 rst = 1'b0;
        #1;
        n_vec++;
        if ({bus.an, bus.seg} !== {4'b1111, 8'hFF}) begin
            n_err++;
            $display("FAIL rst_mid an/seg=%b/%h expected 1111/ff", bus.an, bus.seg);
        end
        bus.ena = 1'b0;
        tick();
        rst     = 1'b1;
        bus.ena = 1'b1;
        tick();
        tick();
        n_vec++;
        if ({bus.an, bus.seg} !== {4'b1110, 8'hC0}) begin
            n_err++;
            $display("FAIL rst_clear an/seg=%b/%h expected 1110/c0", bus.an, bus.seg);
        end
        bus.ena = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_load(32'h89AB_1234);
        test_scan("page0", 1'b0, 4'b0000, 32'hF9A4_B099);
        test_scan("page1", 1'b1, 4'b0000, 32'h8090_8883);
        test_scan("dp2", 1'b0, 4'b0100, 32'hF924_B099);
        test_write_during_drive();
        test_load(32'h0000_0050);
`ifdef SEG_LZ_BLANK_EN
        test_scan("lz", 1'b0, 4'b0000, 32'hFFFF_92C0);
`else
        test_scan("lz", 1'b0, 4'b0000, 32'hC0C0_92C0);
`endif
        test_load(32'h89AB_1234);
        test_ena_drop();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/segment_scan_controller.md
SEGMENT_SCAN_CONTROLLER -- requirements
Module: segment_scan_controller

Interface
REQ-001 Parameter NUM_DIGITS, default 4; number of multiplexed digits, legal range 1..8.
REQ-002 Parameter DATA_W, default 32; width of data_in, SHALL be a multiple of 4*NUM_DIGITS.
REQ-003 Parameter DIV_W, default 18; width of the refresh counter, so each digit is driven for 2**DIV_W cycles.
REQ-004 Parameter BLANK_CYC, default 16; anti-ghosting blank cycles between digits, range 1..2**DIV_W.
REQ-005 Port clk  input  1  single system clock, rising edge.
REQ-006 Port rst  input  1  reset, asynchronous, active-low.
REQ-007 Port ena  input  1  display enable; when 0 all anodes are off.
REQ-008 Port we  input  1  write strobe; captures data_in when 1 on a clk edge.
REQ-009 Port page_sel  input  PAGE_W  selects which 4*NUM_DIGITS-bit slice of the held word is shown; PAGE_W = max(1, clog2(DATA_W/(4*NUM_DIGITS))).
REQ-010 Port data_in  input  DATA_W  word to display.
REQ-011 Port dp_in  input  NUM_DIGITS  decimal-point request per digit, active-high.
REQ-012 Port an  output  NUM_DIGITS  digit anodes, active-low, one-hot-low when driving.
REQ-013 Port seg  output  8  {dp,g,f,e,d,c,b,a}, active-low.

Function
REQ-014 On we=1, data_in SHALL be stored in the hold register at that edge; the new value reaches seg no later than 2 cycles after the edge while that digit is driven.
REQ-015 The visible nibble for digit i SHALL be hold[(page_sel*NUM_DIGITS+i)*4 +: 4]; page_sel >= page count SHALL be treated as page 0.
REQ-016 FSM states OFF, BLANK, DRIVE; OFF->BLANK when ena=1; BLANK->DRIVE after BLANK_CYC cycles; DRIVE->BLANK when the refresh counter reaches 2**DIV_W-1, with the digit index advancing at that transition; any state->OFF on the cycle after ena=0.
REQ-017 The digit index SHALL wrap from NUM_DIGITS-1 to 0; with NUM_DIGITS=1 it stays 0.
REQ-018 In OFF and BLANK, an SHALL be all ones and seg SHALL be 8'hFF; in DRIVE, an SHALL be low only at the current index.
REQ-019 seg[6:0] SHALL be the hex pattern of nibble 0..F; seg[7] SHALL be ~dp_in[index].
REQ-020 an and seg SHALL be registered outputs with no combinational path from any input.
REQ-021 A write during DRIVE SHALL NOT restart the refresh counter or change the digit index.
REQ-022 ena dropping mid-DRIVE and returning SHALL resume at BLANK with the same digit index and the counter cleared.

Reset
REQ-023 While rst=0: state OFF, index 0, refresh and blank counters 0, hold register 0, an all ones, seg 8'hFF.
REQ-024 Reset release SHALL take effect on the first clk edge with rst=1 and no other precondition.

Configuration
REQ-025 With SEG_LZ_BLANK_EN defined, a digit whose nibble and all higher nibbles on the selected page are 0 SHALL show seg 8'hFF except seg[7] per dp_in; digit 0 is never suppressed.
REQ-026 Without SEG_LZ_BLANK_EN, every digit SHALL show its hex pattern, including zeros.

Structure
REQ-027 A shared package seg_pkg SHALL hold the FSM state encoding, the 16-entry active-low hex pattern table and the SEG_OFF constant 8'hFF.
REQ-028 One sub-module seg_hex_decoder (4-bit nibble in, 7-bit pattern out, combinational) SHALL be instantiated.

Verification (NUM_DIGITS=4, DATA_W=32, DIV_W=2, BLANK_CYC=1)
REQ-029 rst=0 then release, ena=0 -> an=4'b1111, seg=8'hFF held for 20 cycles.
REQ-030 we with data_in=32'h89AB_1234, page_sel=0, ena=1 -> scan in order 4,3,2,1: an=1110 with seg=8'h99, 1101 with 8'hB0, 1011 with 8'hA4, 0111 with 8'hF9, each for 4 cycles with 1 blank cycle between; then wrap to 1110.
REQ-031 Same word, page_sel=1 -> digits show B,A,9,8 (8'h83,8'h88,8'h90,8'h80); page_sel=2 -> identical to page 0.
REQ-032 dp_in=4'b0100 -> seg[7]=0 only while an=1011.
REQ-033 SEG_LZ_BLANK_EN defined, data_in=32'h0000_0050, page 0 -> digits 3,2 show 8'hFF, digit 1 shows 8'h92, digit 0 shows 8'hC0; undefined -> digits 3,2 show 8'hC0.
REQ-034 ena=0 for 3 cycles mid-DRIVE on digit 2 -> an=1111 next cycle; on ena=1, one blank cycle then digit 2 driven for 4 full cycles.
